face_result_tx: RTL and testbench

- Return path of the face-detection link. It captures each detection result (top-left row/col plus pyramid level) from the Viola-Jones pipeline, buffers it in a small FIFO and serializes it back to the laptop as fixed 6-byte UART packets (8N1).
- At the end of each image frame it sends a frame-end packet carrying that frame's detection and drop counts.

---
 rtl/face_tx_pkg.sv | 28 ++
 rtl/uart_tx_byte.sv | 62 ++++++
 rtl/face_result_tx.sv | 154 +++++++++++++++
 tb/tb_face_result_tx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/face_tx_pkg.sv
// Shared types and constants for the face-detection result return path.
// Contents:
//   PKT_HEADER / PKT_FRAME_END / PKT_BYTES : packet framing constants
//   fifo_entry_t : one FIFO slot {marker, pyr, row, col}
//   tx_state_t   : packet sequencer states
//   build_packet : maps a FIFO entry onto the 6-byte wire packet (MSB byte first)
package face_tx_pkg;

  localparam logic [7:0] PKT_HEADER    = 8'hA5;
  localparam logic [7:0] PKT_FRAME_END = 8'hFF;
  localparam int         PKT_BYTES     = 6;

  typedef struct packed {
    logic        marker;
    logic [3:0]  pyr;
    logic [15:0] row;
    logic [15:0] col;
  } fifo_entry_t;

  typedef enum logic [1:0] {IDLE, POP, SEND, WAIT} tx_state_t;

  // Marker entries reuse row for det_cnt and col[7:0] for drop_cnt.
  function automatic logic [47:0] build_packet(input fifo_entry_t e);
    if (e.marker) return {PKT_HEADER, PKT_FRAME_END, e.row, e.col[7:0], 8'h00};
    else          return {PKT_HEADER, 4'h0, e.pyr, e.row, e.col};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serializer.
// Ports:
//   clock, reset_n : system clock, async active-low reset (tx forced high)
//   start, data    : start is honoured only while idle; data is captured then
//   tx             : serial line, idle high
//   done           : high during the last cycle of the stop bit
//   active         : a byte is being shifted out
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done,
  output logic       active
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] clk_cnt;
  logic [3:0]    bit_idx;   // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]    shreg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx      <= 1'b1;
      active  <= 1'b0;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (!active) begin
      if (start) begin
        tx      <= 1'b0;
        active  <= 1'b1;
        shreg   <= data;
        bit_idx <= '0;
        clk_cnt <= CW'(CLKS_PER_BIT - 1);
      end
    end else if (clk_cnt != '0) begin
      clk_cnt <= clk_cnt - CW'(1);
    end else begin
      clk_cnt <= CW'(CLKS_PER_BIT - 1);
      if (bit_idx == 4'd9) begin
        active <= 1'b0;
        tx     <= 1'b1;
      end else begin
        bit_idx <= bit_idx + 4'd1;
        if (bit_idx == 4'd8) begin
          tx <= 1'b1;
        end else begin
          tx    <= shreg[0];
          shreg <= {1'b0, shreg[7:1]};
        end
      end
    end
  end

  assign done = active && (bit_idx == 4'd9) && (clk_cnt == '0);

endmodule

// File: rtl/face_result_tx.sv
// Captures detection results, buffers them in a FIFO and sends each as a
// 6-byte UART packet; emits a frame-end packet with per-frame counts.
// Ports:
//   clock, reset_n    : system clock, async active-low reset
//   face_coords       : [0]=row, [1]=col of detection (low 16 bits kept)
//   face_coords_ready : one-cycle detection strobe
//   pyramid_number    : pyramid level of the detection
//   frame_done        : one-cycle end-of-frame strobe
//   tx                : UART out, idle high
//   busy              : FIFO non-empty or packet in flight
//   fifo_count        : FIFO occupancy
//   overflow          : sticky detection-drop flag
module face_result_tx
  import face_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [1:0][31:0]       face_coords,
  input  logic                   face_coords_ready,
  input  logic [3:0]             pyramid_number,
  input  logic                   frame_done,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fifo_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [15:0]   det_cnt;
  logic [7:0]    drop_cnt;
  logic          marker_pending;

  tx_state_t     state;
  logic [47:0]   pkt;
  logic [2:0]    byte_idx;
  logic          ser_start, ser_done, ser_done_q, ser_active;

  logic          push_det, drop, push_mark, push, pop;
  fifo_entry_t   wr_data;
  logic          unused_hi;

  assign unused_hi = ^{face_coords[0][31:16], face_coords[1][31:16]};

  // Last slot is kept free for the frame-end marker.
  assign push_det  = face_coords_ready && (fifo_count < CW'(DEPTH - 1));
  assign drop      = face_coords_ready && !push_det;
  assign push_mark = marker_pending && !push_det && (fifo_count < CW'(DEPTH));
  assign push      = push_det || push_mark;
  assign pop       = (state == POP);

  always_comb begin
    wr_data = '0;
    if (push_det) begin
      wr_data.pyr = pyramid_number;
      wr_data.row = face_coords[0][15:0];
      wr_data.col = face_coords[1][15:0];
    end else begin
      wr_data.marker   = 1'b1;
      wr_data.row      = det_cnt;
      wr_data.col[7:0] = drop_cnt;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      det_cnt        <= '0;
      drop_cnt       <= '0;
      marker_pending <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: ;
      endcase

      // A drop in the marker cycle already belongs to the next frame.
      if (push_mark) begin
        det_cnt  <= '0;
        drop_cnt <= drop ? 8'd1 : 8'd0;
      end else begin
        if (push_det && det_cnt != 16'hFFFF) det_cnt  <= det_cnt + 16'd1;
        if (drop && drop_cnt != 8'hFF)       drop_cnt <= drop_cnt + 8'd1;
      end

      // frame_done while a marker is still pending merges into it.
      if (push_mark)       marker_pending <= 1'b0;
      else if (frame_done) marker_pending <= 1'b1;

      if (drop) overflow <= 1'b1;
    end
  end

  // done is re-registered so bytes inside a packet are separated by two idle cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pkt        <= '0;
      byte_idx   <= '0;
      ser_done_q <= 1'b0;
    end else begin
      ser_done_q <= ser_done;
      unique case (state)
        IDLE: if (fifo_count != '0) state <= POP;
        POP: begin
          pkt      <= build_packet(mem[rd_ptr]);
          byte_idx <= '0;
          state    <= SEND;
        end
        SEND: if (!ser_active) state <= WAIT;
        WAIT: if (ser_done_q) begin
          pkt <= {pkt[39:0], 8'h00};
          if (byte_idx == 3'(PKT_BYTES - 1)) begin
            state <= IDLE;
          end else begin
            byte_idx <= byte_idx + 3'd1;
            state    <= SEND;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ser_start = (state == SEND) && !ser_active;
  assign busy      = (fifo_count != '0) || (state != IDLE);

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clock  (clock),
    .reset_n(reset_n),
    .start  (ser_start),
    .data   (pkt[47:40]),
    .tx     (tx),
    .done   (ser_done),
    .active (ser_active)
  );

endmodule

// File: tb/tb_face_result_tx.sv
// Self-checking bench for face_result_tx: UART receiver on tx, packet-level
// reference model driven alongside the stimulus.
module tb_face_result_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0][31:0] face_coords = '0;
  logic             face_coords_ready = 1'b0;
  logic [3:0]       pyramid_number = '0;
  logic             frame_done = 1'b0;
  logic             tx, busy, overflow;
  logic [2:0]       fifo_count;

  face_result_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .face_coords      (face_coords),
    .face_coords_ready(face_coords_ready),
    .pyramid_number   (pyramid_number),
    .frame_done       (frame_done),
    .tx               (tx),
    .busy             (busy),
    .fifo_count       (fifo_count),
    .overflow         (overflow)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: packet stream and per-frame counters
  logic [7:0]  expq[$];
  int          m_used = 0;
  logic [15:0] m_det  = '0;
  logic [7:0]  m_drop = '0;
  logic        m_ovf  = 1'b0;

  function automatic void mdl_det(input logic [31:0] row, input logic [31:0] col, input logic [3:0] pyr);
    if (m_used < DEPTH - 1) begin
      m_used++;
      if (m_det != 16'hFFFF) m_det++;
      expq.push_back(8'hA5);
      expq.push_back({4'h0, pyr});
      expq.push_back(row[15:8]);
      expq.push_back(row[7:0]);
      expq.push_back(col[15:8]);
      expq.push_back(col[7:0]);
    end else begin
      if (m_drop != 8'hFF) m_drop++;
      m_ovf = 1'b1;
    end
  endfunction

  function automatic void mdl_frame_end();
    expq.push_back(8'hA5);
    expq.push_back(8'hFF);
    expq.push_back(m_det[15:8]);
    expq.push_back(m_det[7:0]);
    expq.push_back(m_drop);
    expq.push_back(8'h00);
    m_det  = '0;
    m_drop = '0;
    m_used++;
  endfunction

  // UART receiver
  logic [7:0] rxq[$];
  int         rx_t[$];

  initial begin : rx_mon
    logic [7:0] b;
    int t;
    forever begin
      @(negedge clock);
      if (reset_n && tx === 1'b0) begin
        t = cyc;
        repeat (CPB / 2) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clock);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clock);
        check_eq("stop_bit", {31'd0, tx}, 32'd1);
        rxq.push_back(b);
        rx_t.push_back(t);
      end
    end
  end

  int last_cyc = 0;

  task automatic drive(input logic rdy, input logic [31:0] row, input logic [31:0] col,
                       input logic [3:0] pyr, input logic fd);
    @(negedge clock);
    face_coords[0]    = row;
    face_coords[1]    = col;
    pyramid_number    = pyr;
    face_coords_ready = rdy;
    frame_done        = fd;
    last_cyc          = cyc + 1;
    if (rdy) mdl_det(row, col, pyr);
    if (fd)  mdl_frame_end();
  endtask

  task automatic release_in();
    @(negedge clock);
    face_coords_ready = 1'b0;
    frame_done        = 1'b0;
  endtask

  task automatic wait_rx(input int budget);
    int k = 0;
    while (rxq.size() < expq.size() && k < budget) begin
      @(negedge clock);
      k++;
    end
    check_eq("rx_count", rxq.size(), expq.size());
  endtask

  task automatic compare_flush();
    for (int i = 0; i < expq.size(); i++) begin
      if (i < rxq.size()) check_eq($sformatf("byte%0d", i), {24'd0, rxq[i]}, {24'd0, expq[i]});
    end
    rxq.delete();
    rx_t.delete();
    expq.delete();
    m_used = 0;
  endtask

  initial begin : main
    int k, guard, nd;
    logic simul;

    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check_eq("rst_tx", {31'd0, tx}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
    check_eq("rst_overflow", {31'd0, overflow}, 32'd0);

    // Single detection: bytes, latency, inter-byte spacing
    drive(1'b1, 32'h0000_0012, 32'h0000_0034, 4'd3, 1'b0);
    k = last_cyc;
    release_in();
    wait_rx(800);
    if (rx_t.size() >= 6) begin
      check_eq("tx_latency", rx_t[0] - k, 32'd3);
      for (int i = 1; i < 6; i++)
        check_eq($sformatf("byte_gap%0d", i), rx_t[i] - rx_t[i-1], 10 * CPB + 2);
    end
    compare_flush();

    // Truncation and high pyramid level, then frame end (2 detections so far)
    drive(1'b1, 32'h0001_ABCD, 32'hDEAD_5678, 4'd8, 1'b0);
    release_in();
    repeat (2) @(negedge clock);
    drive(1'b0, '0, '0, '0, 1'b1);
    release_in();
    wait_rx(1200);
    compare_flush();

    // Three back-to-back detections then frame end
    for (int i = 0; i < 3; i++) drive(1'b1, $urandom, $urandom, 4'($urandom_range(0, 15)), 1'b0);
    release_in();
    drive(1'b0, '0, '0, '0, 1'b1);
    release_in();
    wait_rx(2000);
    compare_flush();

    // Detection and frame_done together: marker follows one cycle later
    drive(1'b1, 32'h0000_0101, 32'h0000_0202, 4'd1, 1'b1);
    release_in();
    check_eq("simul_det_push", {29'd0, fifo_count}, 32'd1);
    @(negedge clock);
    check_eq("simul_marker_push", {29'd0, fifo_count}, 32'd2);
    wait_rx(1200);
    compare_flush();

    // Randomized frames of 0..2 detections
    for (int f = 0; f < 6; f++) begin
      nd    = $urandom_range(0, 2);
      simul = 1'($urandom_range(0, 1)) && (nd > 0);
      for (int d = 0; d < nd; d++) begin
        drive(1'b1, $urandom, $urandom, 4'($urandom_range(0, 15)), simul && (d == nd - 1));
        if ($urandom_range(0, 1) == 1 && d != nd - 1) begin
          release_in();
          repeat ($urandom_range(0, 2)) @(negedge clock);
        end
      end
      release_in();
      if (!simul) begin
        repeat ($urandom_range(0, 2)) @(negedge clock);
        drive(1'b0, '0, '0, '0, 1'b1);
        release_in();
      end
      repeat (2) @(negedge clock);
      wait_rx(1500);
      compare_flush();
    end

    // Empty frame, then overflow while that frame-end packet is on the wire
    drive(1'b0, '0, '0, '0, 1'b1);
    release_in();
    repeat (8) @(negedge clock);
    m_used = 0;
    check_eq("ovf_before", {31'd0, overflow}, {31'd0, m_ovf});
    for (int i = 0; i < 5; i++) drive(1'b1, $urandom, $urandom, 4'($urandom_range(0, 15)), 1'b0);
    release_in();
    check_eq("fifo_full", {29'd0, fifo_count}, 32'(DEPTH - 1));
    check_eq("ovf_after", {31'd0, overflow}, {31'd0, m_ovf});
    drive(1'b0, '0, '0, '0, 1'b1);
    release_in();
    @(negedge clock);
    check_eq("marker_slot", {29'd0, fifo_count}, 32'(DEPTH));
    check_eq("busy_full", {31'd0, busy}, 32'd1);
    wait_rx(3000);
    compare_flush();

    // Reset in the middle of byte 2
    drive(1'b1, 32'h0, 32'h0, 4'd0, 1'b0);
    k = last_cyc;
    release_in();
    guard = 0;
    while (cyc < k + 60 && guard < 300) begin
      @(negedge clock);
      guard++;
    end
    check_eq("tx_low_pre_rst", {31'd0, tx}, 32'd0);
    reset_n = 1'b0;
    #1;
    check_eq("rst_async_tx", {31'd0, tx}, 32'd1);
    check_eq("rst_async_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_async_count", {29'd0, fifo_count}, 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (60) @(negedge clock);
    rxq.delete();
    rx_t.delete();
    expq.delete();
    m_used = 0;
    m_det  = '0;
    m_drop = '0;
    m_ovf  = 1'b0;
    check_eq("ovf_cleared", {31'd0, overflow}, {31'd0, m_ovf});
    drive(1'b1, 32'h0000_55AA, 32'h0000_1234, 4'd5, 1'b0);
    release_in();
    wait_rx(800);
    compare_flush();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
